// File: rtl/nn_pkg.sv
// Shared definitions for the binary-weight network stages: accumulator sizing,
// collector FSM state set and the activation bit encoding used by the next layer.
package nn_pkg;

  // Activation encoding, identical to the next binary layer's weight encoding.
  localparam logic ACT_POS = 1'b1;
  localparam logic ACT_NEG = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SCAN  = 3'd2,
    OUT   = 3'd3,
    CLEAR = 3'd4
  } act_state_t;

  function automatic int acc_w(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/bias_sign_unit.sv
// Combinational bias add followed by sign activation. The sum is one bit wider than
// the accumulator so the most negative accumulator plus the most negative bias cannot wrap.
module bias_sign_unit
  import nn_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     act
);

  localparam logic signed [ACC_W:0] ZERO = '0;

  logic signed [ACC_W:0] sum;

  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(bias);
  assign act = (sum >= ZERO) ? ACT_POS : ACT_NEG;

endmodule

// File: rtl/binary_activation_collector.sv
// Runs one layer pass of the binary input layer: enable neurons, wait for all done,
// serially bias/sign each accumulator into a packed vector, hand it off, clear neurons.
module binary_activation_collector
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 32,
  parameter int WIDTH       = 8,
  parameter int BIAS_W      = 16,
  localparam int ACC_W      = acc_w(WIDTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_NEURONS-1:0][ACC_W-1:0]   neuron_out,
  input  logic [NUM_NEURONS-1:0]              neuron_done,
  input  logic [NUM_NEURONS-1:0][BIAS_W-1:0]  bias,
  output logic                                neuron_en,
  output logic                                neuron_rst,
  output logic [NUM_NEURONS-1:0]              act_out,
  output logic                                act_valid,
  input  logic                                act_ready,
  output logic                                busy
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_RUN   = RUN;
  localparam logic [2:0] ST_SCAN  = SCAN;
  localparam logic [2:0] ST_OUT   = OUT;
  localparam logic [2:0] ST_CLEAR = CLEAR;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic             sign_bit;

  bias_sign_unit #(
    .ACC_W  (ACC_W),
    .BIAS_W (BIAS_W)
  ) u_bias_sign (
    .acc  (neuron_out[idx]),
    .bias (bias[idx]),
    .act  (sign_bit)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)          state_nxt = ST_RUN;
      ST_RUN:   if (&neuron_done)   state_nxt = ST_SCAN;
      ST_SCAN:  if (idx == IDX_LAST) state_nxt = ST_OUT;
      ST_OUT:   if (act_ready)      state_nxt = ST_CLEAR;
      ST_CLEAR:                     state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      // NOTE: the result vector is reset so an aborted pass leaves no partial vector behind.
      act_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_SCAN) begin
        act_out[idx] <= sign_bit;
        idx          <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (state == ST_RUN) begin
        idx <= '0;
      end
    end
  end

  // Neurons are held clear throughout reset as well as during the CLEAR cycle.
  assign neuron_rst = !reset || (state == ST_CLEAR);
  assign neuron_en  = (state == ST_RUN);
  assign act_valid  = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_binary_activation_collector.sv
// Directed bench for binary_activation_collector with a cycle-level reference model of the
// pass sequence and an arithmetic model of the activation vector.
module tb_binary_activation_collector;

  localparam int N      = 4;
  localparam int WIDTH  = 8;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 4 * WIDTH;

  typedef logic [N-1:0][ACC_W-1:0]  acc_vec_t;
  typedef logic [N-1:0][BIAS_W-1:0] bias_vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  acc_vec_t        neuron_out;
  logic [N-1:0]    neuron_done;
  bias_vec_t       bias;
  logic            neuron_en;
  logic            neuron_rst;
  logic [N-1:0]    act_out;
  logic            act_valid;
  logic            act_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int hs_seen = 0;
  int hs_expected = 0;

  binary_activation_collector #(
    .NUM_NEURONS (N),
    .WIDTH       (WIDTH),
    .BIAS_W      (BIAS_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .neuron_out  (neuron_out),
    .neuron_done (neuron_done),
    .bias        (bias),
    .neuron_en   (neuron_en),
    .neuron_rst  (neuron_rst),
    .act_out     (act_out),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Activation vector straight from the arithmetic rule: bit i = (acc_i + bias_i >= 0).
  function automatic logic [N-1:0] expected_vec(input acc_vec_t a, input bias_vec_t b);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      longint s;
      s    = longint'($signed(a[i])) + longint'($signed(b[i]));
      v[i] = (s >= 0);
    end
    return v;
  endfunction

  // Reference model: which phase of a pass we are in, and the last delivered vector.
  typedef enum int {M_IDLE, M_RUN, M_SCAN, M_OUT, M_CLEAR} mphase_t;
  mphase_t      m_phase;
  int           m_left;
  logic [N-1:0] m_act;
  logic [N-1:0] m_next;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= M_IDLE;
      m_left  <= 0;
      m_act   <= '0;
      m_next  <= '0;
    end else begin
      case (m_phase)
        M_IDLE:  if (start) m_phase <= M_RUN;
        M_RUN:   if (neuron_done == {N{1'b1}}) begin
                   m_phase <= M_SCAN;
                   m_left  <= N;
                   m_next  <= expected_vec(neuron_out, bias);
                 end
        M_SCAN:  begin
                   m_left <= m_left - 1;
                   if (m_left == 1) begin
                     m_phase <= M_OUT;
                     m_act   <= m_next;
                   end
                 end
        M_OUT:   if (act_ready) m_phase <= M_CLEAR;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  // Single compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    check("busy", busy, m_phase != M_IDLE);
    check("neuron_en", neuron_en, m_phase == M_RUN);
    check("neuron_rst", neuron_rst, !reset || m_phase == M_CLEAR);
    check("act_valid", act_valid, m_phase == M_OUT);
    if (m_phase != M_SCAN) check("act_out", act_out, m_act);
    if (act_valid && act_ready) hs_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_pass(input string tag, input acc_vec_t a, input bias_vec_t b,
                          input int ready_delay, input bit extra_start, input bit partial,
                          output logic [N-1:0] got);
    int lat;
    neuron_out = a;
    bias       = b;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_run_en"}, neuron_en, 1'b1);
    if (partial) begin
      neuron_done = {1'b0, {(N-1){1'b1}}};
      repeat (50) tick();
      check({tag, "_partial_en"}, neuron_en, 1'b1);
      check({tag, "_partial_valid"}, act_valid, 1'b0);
    end
    if (extra_start) start = 1'b1;
    neuron_done = '1;
    lat = 0;
    do begin
      tick();
      start = 1'b0;
      lat++;
    end while (!act_valid && lat < 100);
    check({tag, "_latency"}, lat, N + 1);
    got = act_out;
    for (int k = 0; k < ready_delay; k++) begin
      start = extra_start && (k == 0);
      tick();
      start = 1'b0;
      check({tag, "_hold_valid"}, act_valid, 1'b1);
      check({tag, "_hold_act"}, act_out, got);
    end
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    hs_expected++;
    check({tag, "_clear_rst"}, neuron_rst, 1'b1);
    check({tag, "_clear_busy"}, busy, 1'b1);
    neuron_done = '0;
    tick();
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_rst"}, neuron_rst, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] got;
    reset       = 1'b0;
    start       = 1'b0;
    act_ready   = 1'b0;
    neuron_done = '0;
    neuron_out  = '0;
    bias        = '0;
    #1;
    check("reset_rst", neuron_rst, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", act_valid, 1'b0);
    check("reset_act", act_out, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    tick();

    // Mixed signs with an exact-zero sum; handoff held off for 10 cycles.
    run_pass("t2", {-32'sd50, 32'sd0, -32'sd3, 32'sd100},
             {16'sd60, 16'sd0, 16'sd3, -16'sd101}, 10, 1'b0, 1'b0, got);
    check("t2_vector", got, 4'b1110);

    // Reset while scanning aborts the pass and clears the vector.
    neuron_out = {32'sd1, 32'sd1, 32'sd1, 32'sd1};
    bias       = '0;
    start      = 1'b1;
    tick();
    start       = 1'b0;
    neuron_done = '1;
    tick();
    tick();
    check("t1_in_scan", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_valid", act_valid, 1'b0);
    check("t1_act", act_out, 4'b0000);
    check("t1_rst", neuron_rst, 1'b1);
    neuron_done = '0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    check("t1_no_emit", act_valid, 1'b0);

    // Extreme accumulators and biases must not wrap.
    run_pass("t4a", {32'sd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000},
             {-16'sd1, 16'sd32767, -16'sd32768, -16'sd1}, 0, 1'b0, 1'b0, got);
    check("t4a_vector", got, 4'b0100);
    run_pass("t4b", {-32'sd7, 32'sd5, -32'sd1, 32'h7FFF_FFFF},
             {16'sd6, -16'sd5, 16'sd0, 16'sd1}, 2, 1'b0, 1'b0, got);
    check("t4b_vector", got, 4'b0101);

    // Start pulses in RUN and OUT are ignored.
    run_pass("t5", {32'sd1, 32'sd2, 32'sd3, 32'sd4}, '0, 3, 1'b1, 1'b0, got);
    check("t5_vector", got, 4'b1111);
    repeat (5) tick();
    check("t5_no_requeue", busy, 1'b0);

    // Three of four done flags: waits in RUN until the fourth arrives.
    run_pass("t6", {-32'sd4, -32'sd3, -32'sd2, -32'sd1}, '0, 1, 1'b0, 1'b1, got);
    check("t6_vector", got, 4'b0000);

    repeat (3) tick();
    check("handshakes", hs_seen, hs_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
